serial_parity_checker: RTL and testbench

- Receive end of the team's XOR-parity serial link.
- Deserialises a frame of DATA_W data bits, LSB first, followed by one parity bit.
- Recomputes parity with a running XOR accumulator, then presents the parallel word together with a parity-error flag.
- Sits between the serial line sampler and the parallel consumer.

---
 rtl/serial_parity_checker.sv | 145 ++++++++++++++
 tb/tb_serial_parity_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Purpose : receive end of the XOR-parity serial link; deserialises DATA_W bits (LSB first) plus one parity bit.
// Latency : out_valid pulses on the edge that samples the parity bit; data_out/parity_err hold until the next frame.
// Backpressure: none; in_valid low stalls the frame indefinitely. Optional error counter: SERIAL_PARITY_ERR_CNT_EN.
module serial_parity_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              busy,
  output logic              abort,
  output logic [7:0]        err_count
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  // Seeding the accumulator with ODD makes a good frame always end at 0.
  localparam logic             ACC_INIT = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              ov_q, ov_d;
  logic              abort_q, abort_d;

  // State and datapath registers; reset discards any frame in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      sreg_q  <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ov_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ov_q    <= ov_d;
      abort_q <= abort_d;
    end
  end

  // Next-state and next-datapath logic; pulses default low, everything else holds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ov_d    = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A bit arriving with the start pulse is not part of the frame.
        if (frame_start) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = ACC_INIT;
        end
      end
      DATA: begin
        if (frame_start) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          acc_d   = ACC_INIT;
        end else if (in_valid) begin
          sreg_d = {in_bit, sreg_q[DATA_W-1:1]};
          acc_d  = acc_q ^ in_bit;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (in_valid) begin
          // Completing frame wins over a coincident start: report it, no abort.
          data_d  = sreg_q;
          perr_d  = acc_q ^ in_bit;
          ov_d    = 1'b1;
          state_d = IDLE;
          if (frame_start) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = ACC_INIT;
          end
        end else if (frame_start) begin
          abort_d = 1'b1;
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = ACC_INIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign out_valid  = ov_q;
  assign abort      = abort_q;
  assign busy       = (state_q != IDLE);

`ifdef SERIAL_PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of frames reported with a parity error; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (ov_d && perr_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

`ifdef SERIAL_PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       in_valid;
  logic       in_bit;

  logic [7:0] e_data, o_data;
  logic       e_ov, o_ov, e_perr, o_perr, e_busy, o_busy, e_abort, o_abort;
  logic [7:0] e_ec, o_ec;

  int checks = 0;
  int errors = 0;
  int exp_ec_e = 0;
  int exp_ec_o = 0;
  int ov_pulses = 0;
  int abort_pulses = 0;

  serial_parity_checker #(.DATA_W(8), .ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid), .in_bit(in_bit),
    .data_out(e_data), .out_valid(e_ov), .parity_err(e_perr), .busy(e_busy), .abort(e_abort),
    .err_count(e_ec)
  );

  serial_parity_checker #(.DATA_W(8), .ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid), .in_bit(in_bit),
    .data_out(o_data), .out_valid(o_ov), .parity_err(o_perr), .busy(o_busy), .abort(o_abort),
    .err_count(o_ec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle on the even instance.
  always @(negedge clk) begin
    if (e_ov === 1'b1) ov_pulses++;
    if (e_abort === 1'b1) abort_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is bad when the XOR of all data bits and the parity bit differs from ODD.
  function automatic logic exp_perr(input logic [7:0] d, input logic p, input int odd);
    int ones;
    ones = $countones(d) + int'(p);
    return ((ones % 2) != odd);
  endfunction

  function automatic int bump(input int cnt, input logic bad);
    if (CNT_EN && bad && cnt < 255) return cnt + 1;
    return cnt;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_e_data"}, e_data, 0);
    check({tag, "_o_data"}, o_data, 0);
    check({tag, "_e_ov"}, e_ov, 0);
    check({tag, "_o_ov"}, o_ov, 0);
    check({tag, "_e_perr"}, e_perr, 0);
    check({tag, "_o_perr"}, o_perr, 0);
    check({tag, "_e_busy"}, e_busy, 0);
    check({tag, "_o_busy"}, o_busy, 0);
    check({tag, "_e_abort"}, e_abort, 0);
    check({tag, "_o_abort"}, o_abort, 0);
    check({tag, "_e_ec"}, e_ec, 0);
    check({tag, "_o_ec"}, o_ec, 0);
  endtask

  task automatic gap(input int mingap, input int maxgap);
    int n;
    n = (maxgap > 0) ? int'($urandom_range(maxgap, mingap)) : 0;
    repeat (n) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      cycle();
      check("gap_busy_e", e_busy, 1);
      check("gap_busy_o", o_busy, 1);
    end
  endtask

  task automatic start();
    frame_start = 1'b1;
    in_valid    = 1'b0;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int mingap, input int maxgap);
    logic [7:0] w;
    w = d;
    for (int i = 0; i < 8; i++) begin
      gap(mingap, maxgap);
      in_valid = 1'b1;
      in_bit   = w[i];
      cycle();
    end
    in_valid = 1'b0;
  endtask

  // Sends the parity bit (optionally with a coincident frame_start) and checks the report.
  task automatic send_parity(input string tag, input logic [7:0] d, input logic p, input logic fs);
    logic be, bo;
    be = exp_perr(d, p, 0);
    bo = exp_perr(d, p, 1);
    exp_ec_e = bump(exp_ec_e, be);
    exp_ec_o = bump(exp_ec_o, bo);
    in_valid    = 1'b1;
    in_bit      = p;
    frame_start = fs;
    cycle();
    in_valid    = 1'b0;
    frame_start = 1'b0;
    check({tag, "_ov_e"}, e_ov, 1);
    check({tag, "_ov_o"}, o_ov, 1);
    check({tag, "_data_e"}, e_data, d);
    check({tag, "_data_o"}, o_data, d);
    check({tag, "_perr_e"}, e_perr, be);
    check({tag, "_perr_o"}, o_perr, bo);
    check({tag, "_ec_e"}, e_ec, exp_ec_e);
    check({tag, "_ec_o"}, o_ec, exp_ec_o);
    check({tag, "_abort_e"}, e_abort, 0);
    check({tag, "_busy_e"}, e_busy, fs);
    if (!fs) begin
      cycle();
      check({tag, "_ov_drop_e"}, e_ov, 0);
      check({tag, "_ov_drop_o"}, o_ov, 0);
      check({tag, "_hold_e"}, e_data, d);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic p, input int mingap, input int maxgap);
    start();
    send_data(d, mingap, maxgap);
    gap(mingap, maxgap);
    send_parity(tag, d, p, 1'b0);
  endtask

  initial begin
    int ov_before, ab_before;
    logic [7:0] rd;
    logic rp;

    rst_n       = 1'b0;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_all_zero("post_reset");

    // Basic even/odd frames.
    frame("a5_p0", 8'hA5, 1'b0, 0, 0);
    frame("a5_p1", 8'hA5, 1'b1, 0, 0);
    frame("01_p0", 8'h01, 1'b0, 0, 0);
    frame("01_p1", 8'h01, 1'b1, 0, 0);

    // Stalls of 1-3 cycles between bits.
    frame("3c_gap_p0", 8'h3C, 1'b0, 1, 3);
    frame("3c_gap_p1", 8'h3C, 1'b1, 1, 3);

    // Abort after 4 bits; the restart cycle carries a valid bit that must be ignored.
    ov_before = ov_pulses;
    ab_before = abort_pulses;
    start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      cycle();
    end
    frame_start = 1'b1;
    in_valid    = 1'b1;
    in_bit      = 1'b0;
    cycle();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    check("abort_pulse_e", e_abort, 1);
    check("abort_pulse_o", o_abort, 1);
    check("abort_busy", e_busy, 1);
    cycle();
    check("abort_drop", e_abort, 0);
    check("abort_no_ov", ov_pulses, ov_before);
    send_data(8'hFF, 0, 0);
    send_parity("after_abort_ff", 8'hFF, 1'b0, 1'b0);
    check("abort_count", abort_pulses, ab_before + 1);

    // Start in IDLE with a valid bit: that bit is not data.
    frame_start = 1'b1;
    in_valid    = 1'b1;
    in_bit      = 1'b1;
    cycle();
    frame_start = 1'b0;
    send_data(8'h00, 0, 0);
    send_parity("idle_start_bit", 8'h00, 1'b0, 1'b0);

    // New frame coinciding with the accepted parity bit.
    ab_before = abort_pulses;
    start();
    send_data(8'h96, 0, 0);
    send_parity("b2b_first", 8'h96, 1'b1, 1'b1);
    send_data(8'h4B, 0, 1);
    send_parity("b2b_second", 8'h4B, 1'b0, 1'b0);
    check("b2b_no_abort", abort_pulses, ab_before);

    // Random frames against the reference.
    for (int k = 0; k < 20; k++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      frame("rand", rd, rp, 0, 2);
    end

    // Asynchronous reset mid-frame.
    start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      cycle();
    end
    in_valid  = 1'b0;
    ov_before = ov_pulses;
    ab_before = abort_pulses;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_all_zero("after_mid_reset");
    check("reset_no_ov", ov_pulses, ov_before);
    check("reset_no_abort", abort_pulses, ab_before);
    exp_ec_e = 0;
    exp_ec_o = 0;

    // Long run of frames bad for the even instance (good for odd) to reach saturation.
    for (int k = 0; k < 260; k++) begin
      rd = 8'($urandom);
      rp = ~(^rd);
      frame("sat", rd, rp, 0, 0);
    end
    check("sat_final_e", e_ec, CNT_EN ? 255 : 0);
    check("sat_final_o", o_ec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
